// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared types and constants for the programmable clock divider/timer
package clkdiv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_PRE_W = 4;

endpackage

// File: rtl/clkdiv_prescaler.sv
// rtl/clkdiv_prescaler.sv - free-running prescaler, built only with CLKDIV_PRESCALE_EN
`ifdef CLKDIV_PRESCALE_EN
module clkdiv_prescaler #(
  parameter int PRE_W = 4
) (
  input  logic clk,
  input  logic arst,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  logic [PRE_W-1:0] cnt;

  // wrap marks the enabled cycle on which the counter rolls over to zero
  assign wrap = en && (&cnt);

  // Prescale counter: clear wins over advance so a fresh start is phase-aligned
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + {{(PRE_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
`endif

// File: rtl/prog_clkdiv_timer.sv
// rtl/prog_clkdiv_timer.sv - programmable divider/interval timer; optional prescaler via CLKDIV_PRESCALE_EN
import clkdiv_pkg::*;

module prog_clkdiv_timer #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             en,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] div_val,
  output logic             tick,
  output logic             clk_out,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  if (WIDTH < 2) begin : g_bad_width
    $error("prog_clkdiv_timer: WIDTH must be at least 2");
  end
  if (PRE_W < 1) begin : g_bad_pre_w
    $error("prog_clkdiv_timer: PRE_W must be at least 1");
  end

  state_t           state;
  logic [WIDTH-1:0] shadow;
  logic             mode_r;

  logic             load_ok;
  logic             start;
  logic             step;
  logic             eff_mode;
  logic [WIDTH-1:0] eff_shadow;

  // A load in the same cycle takes effect before the terminal-count decision
  assign load_ok    = load && (div_val != '0);
  assign start      = (state == IDLE) && load_ok;
  assign eff_mode   = load ? mode : mode_r;
  assign eff_shadow = load_ok ? div_val : shadow;

`ifdef CLKDIV_PRESCALE_EN
  logic pre_wrap;

  clkdiv_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk  (clk),
    .arst (arst),
    .clr  (start),
    .en   (en && (state == RUN)),
    .wrap (pre_wrap)
  );

  assign step = pre_wrap;
`else
  assign step = en;
`endif

  // FSM, down-counter, shadow ratio and all registered outputs
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state   <= IDLE;
      shadow  <= '0;
      mode_r  <= MODE_PERIODIC;
      count   <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
      busy    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (state == IDLE) begin
        if (load_ok) begin
          state  <= RUN;
          busy   <= 1'b1;
          shadow <= div_val;
          mode_r <= mode;
          count  <= div_val - ONE;
        end
      end else begin
        if (load) begin
          mode_r <= mode;
        end
        if (load_ok) begin
          shadow <= div_val;
        end
        if (step) begin
          if (count != '0) begin
            count <= count - ONE;
          end else begin
            tick    <= 1'b1;
            clk_out <= ~clk_out;
            if ((eff_mode == MODE_ONESHOT) && !load_ok) begin
              state <= IDLE;
              busy  <= 1'b0;
              count <= '0;
            end else begin
              count <= eff_shadow - ONE;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_clkdiv_timer.sv
// tb/tb_prog_clkdiv_timer.sv - self-checking bench for prog_clkdiv_timer
module tb_prog_clkdiv_timer;

  localparam int WIDTH = 16;
  localparam int PRE_W = 2;
`ifdef CLKDIV_PRESCALE_EN
  localparam int PS = 1 << PRE_W;
`else
  localparam int PS = 1;
`endif

  logic             clk = 1'b0;
  logic             arst = 1'b0;
  logic             en = 1'b0;
  logic             load = 1'b0;
  logic             mode = 1'b0;
  logic [WIDTH-1:0] div_val = '0;
  logic             tick;
  logic             clk_out;
  logic             busy;
  logic [WIDTH-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  prog_clkdiv_timer #(
    .WIDTH (WIDTH),
    .PRE_W (PRE_W)
  ) dut (
    .clk     (clk),
    .arst    (arst),
    .en      (en),
    .load    (load),
    .mode    (mode),
    .div_val (div_val),
    .tick    (tick),
    .clk_out (clk_out),
    .busy    (busy),
    .count   (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a running period of m_period counted cycles, m_elapsed of them used
  bit m_run, m_oneshot, m_tick, m_clk;
  int m_period, m_ratio, m_elapsed, m_pre;

  function automatic void model_reset();
    m_run = 0; m_oneshot = 0; m_tick = 0; m_clk = 0;
    m_period = 0; m_ratio = 0; m_elapsed = 0; m_pre = 0;
  endfunction

  function automatic int model_count();
    return m_run ? (m_period - 1 - m_elapsed) : 0;
  endfunction

  always @(negedge arst) model_reset();

  always @(posedge clk) begin
    bit lok;
    if (!arst) begin
      model_reset();
    end else begin
      m_tick = 0;
      lok = load && (div_val != 0);
      if (!m_run) begin
        if (lok) begin
          m_run = 1; m_period = div_val; m_ratio = div_val;
          m_elapsed = 0; m_oneshot = mode; m_pre = 0;
        end
      end else begin
        if (load) m_oneshot = mode;
        if (lok) m_ratio = div_val;
        if (en) begin
          m_pre = (m_pre + 1) % PS;
          if (m_pre == 0) begin
            if (m_elapsed == m_period - 1) begin
              m_tick = 1;
              m_clk = !m_clk;
              if (m_oneshot && !lok) m_run = 0;
              else begin
                m_period = m_ratio;
                m_elapsed = 0;
              end
            end else begin
              m_elapsed++;
            end
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, sampled well after the edge
  always @(posedge clk) begin
    #3;
    check("tick", tick, m_tick);
    check("clk_out", clk_out, m_clk);
    check("busy", busy, m_run);
    check("count", count, model_count());
  end

  task automatic do_reset();
    @(negedge clk); arst = 1'b0; load = 1'b0; en = 1'b1;
    @(negedge clk); arst = 1'b1;
  endtask

  task automatic do_load(input int d, input bit m, output int e);
    @(negedge clk); load = 1'b1; div_val = WIDTH'(d); mode = m;
    @(posedge clk); #1; e = cyc;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic wait_tick(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #3;
      if (tick) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, e2, t;
    // Reset held with enable and load activity
    arst = 1'b0; en = 1'b1; div_val = 16'd5;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); load = i[0];
      @(posedge clk); #3;
      check("rst_tick", tick, 0);
      check("rst_clk_out", clk_out, 0);
      check("rst_busy", busy, 0);
      check("rst_count", count, 0);
    end
    @(negedge clk); load = 1'b0; arst = 1'b1;

    // Periodic N=5
    do_reset();
    do_load(5, 0, e);
    wait_tick(200, t); check("per5_t1", t - e, 5 * PS);
    check("per5_clk_hi", clk_out, 1);
    check("per5_busy", busy, 1);
    wait_tick(200, t); check("per5_t2", t - e, 10 * PS);
    check("per5_clk_lo", clk_out, 0);
    wait_tick(200, t); check("per5_t3", t - e, 15 * PS);

    // One-shot N=3
    do_reset();
    do_load(3, 1, e);
    wait_tick(200, t); check("os3_t1", t - e, 3 * PS);
    check("os3_busy", busy, 0);
    wait_tick(20, t); check("os3_none", t, 32'hFFFF_FFFF);

    // Ratio change mid-period, periodic 4 -> 2
    do_reset();
    do_load(4, 0, e);
    do_load(2, 0, e2);
    wait_tick(200, t); check("rc_t1", t - e, 4 * PS);
    wait_tick(200, t); check("rc_t2", t - e, 6 * PS);
    wait_tick(200, t); check("rc_t3", t - e, 8 * PS);

    // div_val=0 in IDLE does not start
    do_reset();
    do_load(0, 0, e);
    @(posedge clk); #3;
    check("zero_busy", busy, 0);
    check("zero_count", count, 0);

    // N=1
    do_load(1, 0, e);
    wait_tick(50, t); check("n1_t1", t - e, PS);
    wait_tick(50, t); check("n1_t2", t - e, 2 * PS);
    wait_tick(50, t); check("n1_t3", t - e, 3 * PS);
    check("n1_clk", clk_out, 1);

    // Pause for 3 cycles mid-count
    do_reset();
    do_load(5, 0, e);
    @(negedge clk); en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    wait_tick(200, t); check("pause_t1", t - e, 5 * PS + 3);

    // Asynchronous reset mid-run
    repeat (2) @(negedge clk);
    arst = 1'b0; #1;
    check("amid_tick", tick, 0);
    check("amid_clk_out", clk_out, 0);
    check("amid_busy", busy, 0);
    check("amid_count", count, 0);
    @(negedge clk); arst = 1'b1;

    // Large ratio: counter starts at div_val-1 and counts down
    do_load(65535, 0, e);
    @(posedge clk); #3;
    check("big_count", count, 65534 - ((PS == 1) ? 1 : 0));

    // Randomised traffic checked by the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      arst = ($urandom_range(0, 299) != 0);
      en   = ($urandom_range(0, 7) != 0);
      load = ($urandom_range(0, 11) == 0);
      mode = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 49) == 0) div_val = WIDTH'($urandom);
      else div_val = WIDTH'($urandom_range(0, 9));
    end
    @(negedge clk); arst = 1'b1; load = 1'b0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
